// File: rtl/galois_permute_if.sv
// Frame control, coefficient beat stream and per-lane BRAM write bundle for galois_permute.
interface galois_permute_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int MODULUS_WIDTH = 35,
    parameter int LOG_N         = 12,
    parameter int LANES         = 2
);
    logic                             i_start;
    logic [LOG_N:0]                   i_galois_elt;
    logic [MODULUS_WIDTH-1:0]         i_modulus;
    logic                             i_mode;
    logic                             i_valid;
    logic [LANES*MODULUS_WIDTH-1:0]   i_data;
    logic                             o_ready;
    logic [LANES-1:0]                 o_we;
    logic [LANES*LOG_N-1:0]           o_addr;
    logic [LANES*DATA_WIDTH-1:0]      o_data;
    logic                             o_busy;
    logic                             o_done;
    logic                             o_err;

    modport master (
        output i_start, i_galois_elt, i_modulus, i_mode, i_valid, i_data,
        input  o_ready, o_we, o_addr, o_data, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_galois_elt, i_modulus, i_mode, i_valid, i_data,
        output o_ready, o_we, o_addr, o_data, o_busy, o_done, o_err
    );
endinterface

// File: rtl/galois_permute.sv
// Galois automorphism X->X^g (or identity bypass) on a coefficient stream, emitting per-lane BRAM writes.
// Accepted beat appears on o_we two cycles after its accept edge, II=1; o_ready only in RUN, other beats dropped.
module galois_permute #(
    parameter int DATA_WIDTH    = 64,
    parameter int MODULUS_WIDTH = 35,
    parameter int LOG_N         = 12,
    parameter int LANES         = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    galois_permute_if.slave bus
);
    localparam int IW    = LOG_N + 1;
    localparam int BEATS = (1 << LOG_N) / LANES;
    localparam logic [LOG_N-1:0] LAST_BEAT = LOG_N'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic                                mode_q, mode_d;
    logic [IW-1:0]                       g_q, g_d;
    logic [MODULUS_WIDTH-1:0]            q_q, q_d;
    logic [LANES-1:0][IW-1:0]            off_q, off_d;
    logic [IW-1:0]                       base_q, base_d;
    logic [LOG_N-1:0]                    beat_q, beat_d;
    logic                                drain_q, drain_d;
    logic                                err_q, err_d;

    logic                                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [LANES-1:0][IW-1:0]            s1_idx_q, s1_idx_d;
    logic [LANES-1:0][MODULUS_WIDTH-1:0] s1_dat_q, s1_dat_d;
    logic                                s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [LANES-1:0][LOG_N-1:0]         s2_addr_q, s2_addr_d;
    logic [LANES-1:0]                    s2_neg_q, s2_neg_d;
    logic [LANES-1:0][MODULUS_WIDTH-1:0] s2_dat_q, s2_dat_d;
    logic [LANES-1:0]                    we_q, we_d;
    logic [LANES-1:0][LOG_N-1:0]         addr_q, addr_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]    dat_q, dat_d;
    logic                                last_q, last_d, done_q, done_d;

    logic [LANES-1:0][MODULUS_WIDTH-1:0] in_dat;
    logic                                accept;
    logic [IW-1:0]                       j;
    logic [MODULUS_WIDTH-1:0]            neg_val;

    assign in_dat = bus.i_data;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        g_d      = g_q;
        q_d      = q_q;
        off_d    = off_q;
        base_d   = base_q;
        beat_d   = beat_q;
        drain_d  = 1'b0;
        err_d    = 1'b0;
        accept   = 1'b0;
        j        = '0;
        neg_val  = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_mode || bus.i_galois_elt[0]) begin
                        state_d = LOAD;
                        mode_d  = bus.i_mode;
                        g_d     = bus.i_galois_elt;
                        q_d     = bus.i_modulus;
                        base_d  = '0;
                        beat_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Lane offsets l*g mod 2N, so each lane only needs one add per beat.
                for (int l = 0; l < LANES; l++) begin
                    off_d[l] = IW'(l) * g_q;
                end
                state_d = RUN;
            end
            RUN: begin
                if (bus.i_valid) begin
                    accept = 1'b1;
                    base_d = base_q + IW'(LANES) * g_q;
                    beat_d = beat_q + LOG_N'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stage 1: full index mod 2N; bypass forces the sign bit clear.
        s1_vld_d  = accept;
        s1_last_d = accept && (beat_q == LAST_BEAT);
        s1_idx_d  = s1_idx_q;
        s1_dat_d  = s1_dat_q;
        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                j           = IW'(beat_q) * IW'(LANES) + IW'(l);
                s1_idx_d[l] = mode_q ? {1'b0, j[LOG_N-1:0]} : base_q + off_q[l];
                s1_dat_d[l] = in_dat[l];
            end
        end

        // Stage 2: split index into BRAM address and X^N = -1 sign.
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;
        s2_addr_d = s2_addr_q;
        s2_neg_d  = s2_neg_q;
        s2_dat_d  = s2_dat_q;
        if (s1_vld_q) begin
            for (int l = 0; l < LANES; l++) begin
                s2_addr_d[l] = s1_idx_q[l][LOG_N-1:0];
                s2_neg_d[l]  = s1_idx_q[l][LOG_N];
                s2_dat_d[l]  = s1_dat_q[l];
            end
        end

        // Output stage: conditional negation; address/data hold while o_we is low.
        we_d   = {LANES{s2_vld_q}};
        last_d = s2_vld_q && s2_last_q;
        done_d = last_q;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (s2_vld_q) begin
            for (int l = 0; l < LANES; l++) begin
                neg_val   = (s2_dat_q[l] == '0) ? '0 : q_q - s2_dat_q[l];
                addr_d[l] = s2_addr_q[l];
                dat_d[l]  = DATA_WIDTH'(s2_neg_q[l] ? neg_val : s2_dat_q[l]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            g_q       <= '0;
            q_q       <= '0;
            off_q     <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            drain_q   <= 1'b0;
            err_q     <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_idx_q  <= '0;
            s1_dat_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_addr_q <= '0;
            s2_neg_q  <= '0;
            s2_dat_q  <= '0;
            we_q      <= '0;
            addr_q    <= '0;
            dat_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            g_q       <= g_d;
            q_q       <= q_d;
            off_q     <= off_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_idx_q  <= s1_idx_d;
            s1_dat_q  <= s1_dat_d;
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            s2_addr_q <= s2_addr_d;
            s2_neg_q  <= s2_neg_d;
            s2_dat_q  <= s2_dat_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_ready = (state_q == RUN);
    assign bus.o_busy  = (state_q != IDLE);
    assign bus.o_we    = we_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_data  = dat_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
endmodule
